// File: rtl/reg_bank_arb_pkg.sv
// Shared constants and types for the arbitrated register bank.
// FSM encoding and the flop delay constant used by timing-aware benches.
package reg_bank_arb_pkg;

  localparam int unsigned T_FF_DELAY = 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_WRITE = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StWrite = ST_WRITE
  } state_e;

  // Width of an index into n items, never zero.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_arb_if.sv
// Requester/read bus of the arbitrated register bank.
// master: requesters and reader; slave: the bank itself.
interface reg_bank_arb_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W     = 8,
   parameter int unsigned AW    = 2
);

   logic [N_REQ-1:0]    req;
   logic [N_REQ*AW-1:0] req_addr;
   logic [N_REQ*W-1:0]  req_data;
   logic [N_REQ-1:0]    gnt;
   logic                busy;
   logic                addr_err;
   logic [AW-1:0]       rd_addr;
   logic [W-1:0]        rd_data;

   modport master (
      output req, req_addr, req_data, rd_addr,
      input  gnt, busy, addr_err, rd_data
   );

   modport slave (
      input  req, req_addr, req_data, rd_addr,
      output gnt, busy, addr_err, rd_data
   );

endinterface

// File: rtl/ff_d.sv
// N-bit enabled D register with asynchronous active-low clear.
module ff_d #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         res_n,
   input  logic         en,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         dout <= '0;
      end else if (en) begin
         dout <= din;
      end
   end

endmodule

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set req scanning from ptr upward with wrap.
module rr_pick
   import reg_bank_arb_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IdxW = idx_width(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] ptr,
   output logic            valid,
   output logic [IdxW-1:0] idx
);

   int cand;

   // Scan offsets from the far end so the offset closest to ptr is written last and wins.
   always_comb begin
      idx  = '0;
      cand = 0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         cand = int'(ptr) + i;
         if (cand >= int'(N)) begin
            cand = cand - int'(N);
         end
         if (req[cand]) begin
            idx = IdxW'(cand);
         end
      end
      valid = |req;
   end

endmodule

// File: rtl/reg_bank_arb.sv
// Register bank with one write port shared by N_REQ requesters via a round-robin arbiter.
// Two-state FSM: IDLE samples and stages the winner, WRITE commits it for exactly one cycle.
module reg_bank_arb
   import reg_bank_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic         clk,
   input  logic         res_n,
   reg_bank_arb_if.slave bus
);

   localparam int unsigned IdxW    = idx_width(N_REQ);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(N_REQ - 1);
   localparam logic [AW:0]     DepthW  = (AW + 1)'(DEPTH);

   state_e          state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] sel_q, sel_d;
   logic [AW-1:0]   stg_addr_q, stg_addr_d;
   logic [W-1:0]    stg_data_q, stg_data_d;

   logic            pick_valid;
   logic [IdxW-1:0] pick_idx;
   logic            write_act;
   logic            in_range;
   logic [DEPTH-1:0] reg_en;
   logic [W-1:0]    bank_q [DEPTH];

   rr_pick #(
      .N(N_REQ)
   ) u_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      sel_d      = sel_q;
      stg_addr_d = stg_addr_q;
      stg_data_d = stg_data_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               sel_d      = pick_idx;
               stg_addr_d = bus.req_addr[pick_idx*AW +: AW];
               stg_data_d = bus.req_data[pick_idx*W +: W];
               state_d    = StWrite;
            end
         end
         StWrite: begin
            ptr_d   = (sel_q == LastIdx) ? '0 : sel_q + 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         sel_q      <= '0;
         stg_addr_q <= '0;
         stg_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         sel_q      <= sel_d;
         stg_addr_q <= stg_addr_d;
         stg_data_q <= stg_data_d;
      end
   end

   // Outputs decode the registered state only, so reset clears them without waiting for clk.
   assign write_act = (state_q == StWrite);
   assign in_range  = ({1'b0, stg_addr_q} < DepthW);

   always_comb begin
      bus.gnt = '0;
      if (write_act) begin
         bus.gnt[sel_q] = 1'b1;
      end
   end

   assign bus.busy     = write_act;
   assign bus.addr_err = write_act & ~in_range;

   for (genvar k = 0; k < DEPTH; k++) begin : g_bank
      assign reg_en[k] = write_act && (stg_addr_q == AW'(k));

      ff_d #(
         .N(W)
      ) u_reg (
         .clk   (clk),
         .res_n (res_n),
         .en    (reg_en[k]),
         .din   (stg_data_q),
         .dout  (bank_q[k])
      );
   end

   always_comb begin
      bus.rd_data = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         if (bus.rd_addr == AW'(k)) begin
            bus.rd_data = bank_q[k];
         end
      end
   end

   a_reg_en_onehot: assert property (@(posedge clk) disable iff (!res_n) $onehot0(reg_en));
   a_gnt_onehot:    assert property (@(posedge clk) disable iff (!res_n) $onehot0(bus.gnt));

endmodule
